// File: rtl/sid_ext_filter_pkg.sv
// Shared types, constants and helpers for the SID board-level output stage.
package sid_ext_filter_pkg;

  typedef logic signed [15:0] s16_t;
  typedef logic signed [21:0] s22_t;
  typedef logic signed [31:0] s32_t;
  typedef logic signed [32:0] s33_t;
  typedef logic signed [40:0] s41_t;

  // LP coefficient w0*T in Q7, HP coefficient w0*T in Q17
  localparam logic [7:0] EXT_W_LP     = 8'd13;
  localparam logic [7:0] EXT_W_HP     = 8'd14;
  localparam int         EXT_LP_SHIFT = 7;
  localparam int         EXT_HP_SHIFT = 17;
  localparam int         EXT_FRAC     = 9;
  localparam int         EXT_OSHIFT   = 6;

  typedef struct packed {
    s32_t vlp;
    s32_t vhp;
  } ext_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LP   = 2'd1,
    ST_HP   = 2'd2,
    ST_OUT  = 2'd3
  } ext_fsm_t;

  // Saturate a 32-bit signed value into the 16-bit audio range
  function automatic s16_t clamp16(input s32_t v);
    if (v > 32'sh0000_7FFF)      return 16'sh7FFF;
    else if (v < 32'shFFFF_8000) return 16'sh8000;
    else                         return v[15:0];
  endfunction

endpackage

// File: rtl/sid_ext_filter_mac.sv
// Shared multiply-accumulate for the LP and HP filter steps:
// sum = acc + ((diff * coef) >>> shift), shift selected between the LP and HP scalings.
module sid_ext_mac
  import sid_ext_filter_pkg::*;
(
  input  logic signed [32:0] diff,
  input  logic [7:0]         coef,
  input  logic               hp_shift,
  input  logic signed [31:0] acc,
  output logic signed [31:0] sum
);

  s41_t prod;
  s41_t prod_shr;

  // Coefficient is unsigned, so widen it with a zero sign bit before the signed multiply
  always_comb begin
    prod     = s41_t'(diff) * s41_t'($signed({1'b0, coef}));
    prod_shr = hp_shift ? (prod >>> EXT_HP_SHIFT) : (prod >>> EXT_LP_SHIFT);
    sum      = acc + s32_t'(prod_shr);
  end

endmodule

// File: rtl/sid_ext_filter.sv
// C64 board output stage: one-pole RC low-pass followed by one-pole RC high-pass
// (DC block), one shared multiplier sequenced IDLE -> LP -> HP -> OUT.
module sid_ext_filter
  import sid_ext_filter_pkg::*;
#(
  parameter logic [7:0] W_LP   = EXT_W_LP,
  parameter logic [7:0] W_HP   = EXT_W_HP,
  parameter int         FRAC   = EXT_FRAC,
  parameter int         OSHIFT = EXT_OSHIFT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [21:0] audio_i,
  input  logic               enable,
  output logic               ready,
  output logic               out_valid,
  output logic signed [15:0] audio_o,
  output logic               overrun
);

  ext_fsm_t   state_q, state_d;
  ext_state_t st_q;
  s22_t       x_p0;
  logic       en_p0;

  s32_t       x_scaled;
  s33_t       mac_diff;
  logic [7:0] mac_coef;
  logic       mac_hp;
  s32_t       mac_acc;
  s32_t       mac_sum;

  s33_t       out_diff;
  s32_t       out_shr;
  s16_t       out_filt;
  s16_t       out_byp;

  assign ready    = (state_q == ST_IDLE);
  assign x_scaled = s32_t'(x_p0) <<< FRAC;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: a sample is only taken in IDLE, then three fixed steps
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_LP;
      ST_LP:   state_d = ST_HP;
      ST_HP:   state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the sample and its bypass mode at accept; later enable changes are ignored
  always_ff @(posedge clk) begin
    if (in_valid && ready) begin
      x_p0  <= audio_i;
      en_p0 <= enable;
    end
  end

  // Operand steering for the shared multiplier: LP tracks the input, HP tracks the fresh LP state
  always_comb begin
    mac_hp   = (state_q == ST_HP);
    mac_coef = mac_hp ? W_HP : W_LP;
    mac_acc  = mac_hp ? st_q.vhp : st_q.vlp;
    mac_diff = mac_hp ? (s33_t'(st_q.vlp) - s33_t'(st_q.vhp))
                      : (s33_t'(x_scaled) - s33_t'(st_q.vlp));
  end

  sid_ext_mac u_mac (
    .diff     (mac_diff),
    .coef     (mac_coef),
    .hp_shift (mac_hp),
    .acc      (mac_acc),
    .sum      (mac_sum)
  );

  // HP output can approach twice full scale, so the difference is kept 33 bits wide
  assign out_diff = s33_t'(st_q.vlp) - s33_t'(mac_sum);
  assign out_shr  = s32_t'(out_diff >>> (FRAC + OSHIFT));
  assign out_filt = clamp16(out_shr);
  assign out_byp  = s16_t'(x_p0 >>> OSHIFT);

  // Filter state, output register and sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= '0;
      audio_o   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && !ready) overrun <= 1'b1;
      case (state_q)
        // ---- LP step ----
        ST_LP: st_q.vlp <= en_p0 ? mac_sum : x_scaled;
        // ---- HP step, output registered so it is visible during OUT ----
        ST_HP: begin
          st_q.vhp  <= en_p0 ? mac_sum : '0;
          audio_o   <= en_p0 ? out_filt : out_byp;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sid_ext_filter.sv
// Self-checking bench for sid_ext_filter: per-sample behavioural model plus
// a per-cycle compare process, directed literal cases and a randomized run.
module tb_sid_ext_filter;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [21:0] audio_i = '0;
  logic               enable = 1'b1;
  logic               ready;
  logic               out_valid;
  logic signed [15:0] audio_o;
  logic               overrun;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;
  int ov_count = 0;

  // Model state (whole sample computed at accept, released three cycles later)
  longint m_vlp = 0, m_vhp = 0, m_out = 0, m_pend = 0;
  int     m_phase = 0;
  bit     m_ovalid = 1'b0, m_over = 1'b0;

  sid_ext_filter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .audio_i   (audio_i),
    .enable    (enable),
    .ready     (ready),
    .out_valid (out_valid),
    .audio_o   (audio_o),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endfunction

  function automatic longint sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Both filter equations applied in one go to a newly accepted sample
  function automatic void model_accept(input longint x, input bit en);
    if (en) begin
      m_vlp  = m_vlp + ((13 * (x * 512 - m_vlp)) >>> 7);
      m_vhp  = m_vhp + ((14 * (m_vlp - m_vhp)) >>> 17);
      m_pend = sat16((m_vlp - m_vhp) >>> 15);
    end else begin
      m_vlp  = x * 512;
      m_vhp  = 0;
      m_pend = x >>> 6;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_vlp = 0; m_vhp = 0; m_out = 0; m_pend = 0;
      m_phase = 0; m_ovalid = 1'b0; m_over = 1'b0;
    end else begin
      m_ovalid = 1'b0;
      if (m_phase == 0) begin
        if (in_valid) begin
          model_accept(longint'(audio_i), enable);
          m_phase = 1;
        end
      end else begin
        if (in_valid) m_over = 1'b1;
        m_phase = m_phase + 1;
        if (m_phase == 3) begin
          m_ovalid = 1'b1;
          m_out    = m_pend;
        end
        if (m_phase == 4) m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cmp_ready",     longint'(ready),     longint'(m_phase == 0));
      check("cmp_out_valid", longint'(out_valid), longint'(m_ovalid));
      check("cmp_audio_o",   longint'(audio_o),   m_out);
      check("cmp_overrun",   longint'(overrun),   longint'(m_over));
    end
    if (out_valid === 1'b1) ov_count++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // One sample at full throughput (4 clocks), returning the value seen during OUT
  task automatic send(input logic signed [21:0] x, input logic en, output int y);
    audio_i = x; enable = en; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    @(negedge clk);
    y = int'(audio_o);
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int y, peak, vmax, vmin, cnt0;

    // Reset state
    rst = 1'b1;
    step(); chk_on = 1'b1; step();
    @(negedge clk);
    check("rst_audio_o", longint'(audio_o), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_overrun", longint'(overrun), 0);
    check("rst_ready", longint'(ready), 1);
    step();
    rst = 1'b0;
    cnt0 = ov_count;
    repeat (10) step();
    check("idle_no_out_valid", ov_count - cnt0, 0);

    // First step response with exact latency
    audio_i = 22'sh100000; enable = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_valid", longint'(out_valid), 0);
    check("lat_c1_ready", longint'(ready), 0);
    step(); @(negedge clk);
    check("lat_c2_valid", longint'(out_valid), 0);
    step(); @(negedge clk);
    check("lat_c3_valid", longint'(out_valid), 1);
    check("step_audio_o", longint'(audio_o), 1663);
    check("model_vlp_step", m_vlp, 54525952);
    check("model_vhp_step", m_vhp, 5824);
    step();

    // Bypass
    send(22'sh0FFFC0, 1'b0, y);
    check("bypass_audio_o", y, 16383);
    check("model_vlp_byp", m_vlp, 64'sd1048512 * 512);
    check("model_vhp_byp", m_vhp, 0);

    // Overrun then reset abort
    do_reset();
    audio_i = 22'sh100000; enable = 1'b1; in_valid = 1'b1;
    step();
    audio_i = 22'sh1FFFFF; enable = 1'b0;
    step();
    in_valid = 1'b0;
    step(); @(negedge clk);
    check("ovr_valid", longint'(out_valid), 1);
    check("ovr_audio_o", longint'(audio_o), 1663);
    check("ovr_flag", longint'(overrun), 1);
    step();
    audio_i = 22'sh0ABCDE; enable = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    cnt0 = ov_count;
    step(); @(negedge clk);
    check("abort_out_valid", longint'(out_valid), 0);
    check("abort_audio_o", longint'(audio_o), 0);
    check("abort_overrun", longint'(overrun), 0);
    check("abort_ready", longint'(ready), 1);
    step();
    rst = 1'b0;
    repeat (6) step();
    check("abort_no_out_valid", ov_count - cnt0, 0);

    // DC block: constant input, output peaks then decays
    do_reset();
    peak = -40000; vmax = -40000;
    for (int i = 0; i < 2000; i++) begin
      send(22'sh100000, 1'b1, y);
      if (y > peak) peak = y;
      if (y > vmax) vmax = y;
    end
    check("dc_peak_in_range", longint'(peak >= 16200 && peak <= 16384), 1);
    check("dc_decay_in_range", longint'(y >= 12900 && y <= 13500), 1);
    check("dc_no_clamp", longint'(vmax < 32767), 1);

    // Clamp: partly-settled positive level, then full negative step
    do_reset();
    for (int i = 0; i < 1500; i++) send(22'sh1FFFFF, 1'b1, y);
    vmin = 40000;
    for (int i = 0; i < 40; i++) begin
      send(22'sh200000, 1'b1, y);
      if (y < vmin) vmin = y;
    end
    check("clamp_neg_reached", vmin, -32768);

    // Randomized traffic, busy inputs, enable flips and occasional reset
    for (int i = 0; i < 4000; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      audio_i  = 22'($urandom);
      enable   = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
